cache_write_buffer: RTL and testbench



---
 rtl/lc3b_types.sv | 18 +
 rtl/write_buffer_entry.sv | 49 ++++
 rtl/cache_write_buffer.sv | 167 ++++++++++++++++
 tb/tb_cache_write_buffer.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared types for the LC-3b memory hierarchy.
//   lc3b_word     : 16-bit byte address / data word
//   lc3b_line     : 128-bit cache line
//   lc3b_line_tag : line address, i.e. byte address bits [15:4]
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;
    typedef logic [11:0]  lc3b_line_tag;

    localparam int LINE_OFFSET_BITS = 4;

    // Line-aligned byte address for a line tag.
    function automatic lc3b_word line_base(input lc3b_line_tag tag);
        return {tag, {LINE_OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/write_buffer_entry.sv
// Single write-buffer entry: valid bit, line tag and line data.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   load                    capture load_tag/load_data and set valid
//   clear                   drop the entry (load wins if both are high)
//   load_tag, load_data     line to capture
//   lookup_tag              tag compared against the held line
//   valid, tag, data        current entry contents
//   match                   entry valid and tag equal to lookup_tag
module write_buffer_entry
    import lc3b_types::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic         clear,
    input  lc3b_line_tag load_tag,
    input  lc3b_line     load_data,
    input  lc3b_line_tag lookup_tag,
    output logic         valid,
    output lc3b_line_tag tag,
    output lc3b_line     data,
    output logic         match
);

    logic         valid_reg;
    lc3b_line_tag tag_reg;
    lc3b_line     data_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_reg <= 1'b0;
            tag_reg   <= '0;
            data_reg  <= '0;
        end else if (load) begin
            valid_reg <= 1'b1;
            tag_reg   <= load_tag;
            data_reg  <= load_data;
        end else if (clear) begin
            valid_reg <= 1'b0;
        end
    end

    assign valid = valid_reg;
    assign tag   = tag_reg;
    assign data  = data_reg;
    assign match = valid_reg && (tag_reg == lookup_tag);

endmodule

// File: rtl/cache_write_buffer.sv
// Single-entry eviction write buffer between the L1 cache and physical memory.
// Evictions are absorbed in one cycle, reads hitting the buffered line are
// forwarded, and the buffered line drains whenever the memory port is idle.
// Ports:
//   clk, reset_n                         clock, asynchronous active-low reset
//   cache_read/cache_write               cache requests, held until cache_resp
//   cache_address, cache_wdata           request address (bits [3:0] ignored), eviction data
//   cache_rdata, cache_resp              read data and one-cycle completion pulse
//   pmem_read/pmem_write                 memory strobes, held until pmem_resp
//   pmem_address, pmem_wdata             line-aligned memory address, drain data
//   pmem_rdata, pmem_resp                fill data and memory completion pulse
// All outputs are registered: the output flops load their next values on the
// same edge that the FSM changes state.
module cache_write_buffer
    import lc3b_types::*;
(
    input  logic     clk,
    input  logic     reset_n,
    input  logic     cache_read,
    input  logic     cache_write,
    input  lc3b_word cache_address,
    input  lc3b_line cache_wdata,
    output lc3b_line cache_rdata,
    output logic     cache_resp,
    output logic     pmem_read,
    output logic     pmem_write,
    output lc3b_word pmem_address,
    output lc3b_line pmem_wdata,
    input  lc3b_line pmem_rdata,
    input  logic     pmem_resp
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t       state_reg, state_next;

    lc3b_line     cache_rdata_reg, cache_rdata_next;
    logic         cache_resp_reg, cache_resp_next;
    logic         pmem_read_reg, pmem_read_next;
    logic         pmem_write_reg, pmem_write_next;
    lc3b_word     pmem_address_reg, pmem_address_next;
    lc3b_line     pmem_wdata_reg, pmem_wdata_next;

    logic         entry_load, entry_clear;
    logic         wb_valid, wb_match;
    lc3b_line_tag wb_tag;
    lc3b_line     wb_data;
    lc3b_line_tag req_tag;

    logic         unused_offset;

    assign req_tag       = cache_address[15:4];
    assign unused_offset = ^cache_address[3:0];

    write_buffer_entry u_entry (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (entry_load),
        .clear      (entry_clear),
        .load_tag   (req_tag),
        .load_data  (cache_wdata),
        .lookup_tag (req_tag),
        .valid      (wb_valid),
        .tag        (wb_tag),
        .data       (wb_data),
        .match      (wb_match)
    );

    always_comb begin
        state_next        = state_reg;
        cache_rdata_next  = cache_rdata_reg;
        cache_resp_next   = 1'b0;
        pmem_read_next    = 1'b0;
        pmem_write_next   = 1'b0;
        pmem_address_next = pmem_address_reg;
        pmem_wdata_next   = pmem_wdata_reg;
        entry_load        = 1'b0;
        entry_clear       = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (cache_read && wb_match) begin
                    cache_rdata_next = wb_data;
                    cache_resp_next  = 1'b1;
                    state_next       = RESP;
                end else if (cache_read) begin
                    pmem_read_next    = 1'b1;
                    pmem_address_next = line_base(req_tag);
                    state_next        = FILL;
                end else if (cache_write && (!wb_valid || wb_match)) begin
                    // Empty buffer or same line: capture (or overwrite) now.
                    entry_load      = 1'b1;
                    cache_resp_next = 1'b1;
                    state_next      = RESP;
                end else if (wb_valid) begin
                    // Either an eviction of a different line is waiting, or the
                    // port is idle: push the buffered line out. A pending write
                    // is then accepted from IDLE once the buffer is empty.
                    pmem_write_next   = 1'b1;
                    pmem_address_next = line_base(wb_tag);
                    pmem_wdata_next   = wb_data;
                    state_next        = DRAIN;
                end
            end

            FILL: begin
                if (pmem_resp) begin
                    cache_rdata_next = pmem_rdata;
                    cache_resp_next  = 1'b1;
                    state_next       = RESP;
                end else begin
                    pmem_read_next = 1'b1;
                end
            end

            DRAIN: begin
                if (pmem_resp) begin
                    entry_clear = 1'b1;
                    state_next  = IDLE;
                end else begin
                    pmem_write_next = 1'b1;
                end
            end

            RESP: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= IDLE;
            cache_rdata_reg  <= '0;
            cache_resp_reg   <= 1'b0;
            pmem_read_reg    <= 1'b0;
            pmem_write_reg   <= 1'b0;
            pmem_address_reg <= '0;
            pmem_wdata_reg   <= '0;
        end else begin
            state_reg        <= state_next;
            cache_rdata_reg  <= cache_rdata_next;
            cache_resp_reg   <= cache_resp_next;
            pmem_read_reg    <= pmem_read_next;
            pmem_write_reg   <= pmem_write_next;
            pmem_address_reg <= pmem_address_next;
            pmem_wdata_reg   <= pmem_wdata_next;
        end
    end

    assign cache_rdata  = cache_rdata_reg;
    assign cache_resp   = cache_resp_reg;
    assign pmem_read    = pmem_read_reg;
    assign pmem_write   = pmem_write_reg;
    assign pmem_address = pmem_address_reg;
    assign pmem_wdata   = pmem_wdata_reg;

endmodule

// File: tb/tb_cache_write_buffer.sv
// Directed testbench for cache_write_buffer with a small memory model that
// answers strobes after a programmable latency and logs every memory access.
module tb_cache_write_buffer;

    logic         clk;
    logic         reset_n;
    logic         cache_read;
    logic         cache_write;
    logic [15:0]  cache_address;
    logic [127:0] cache_wdata;
    logic [127:0] cache_rdata;
    logic         cache_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    int checks = 0;
    int errors = 0;

    cache_write_buffer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cache_read    (cache_read),
        .cache_write   (cache_write),
        .cache_address (cache_address),
        .cache_wdata   (cache_wdata),
        .cache_rdata   (cache_rdata),
        .cache_resp    (cache_resp),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_address  (pmem_address),
        .pmem_wdata    (pmem_wdata),
        .pmem_rdata    (pmem_rdata),
        .pmem_resp     (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    typedef struct {
        bit           wr;
        logic [15:0]  addr;
        logic [127:0] data;
    } mem_op_t;

    mem_op_t      mem_log[$];
    logic [127:0] mem [logic [11:0]];
    int           mem_lat   = 2;
    bit           mem_hold  = 0;
    bit           stray_req = 0;
    bit           overlap_seen = 0;
    int           mem_cnt = 0;

    function automatic logic [127:0] mem_fetch(input logic [11:0] t);
        if (mem.exists(t)) return mem[t];
        return {8{t, 4'h5}};
    endfunction

    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
    end

    always @(negedge clk) begin
        if (pmem_read && pmem_write) overlap_seen = 1;
        if (pmem_resp) begin
            pmem_resp = 1'b0;
            mem_cnt   = 0;
        end else if ((pmem_read || pmem_write) && !mem_hold) begin
            mem_cnt++;
            if (mem_cnt >= mem_lat) begin
                mem_op_t op;
                op.wr   = pmem_write;
                op.addr = pmem_address;
                op.data = pmem_write ? pmem_wdata : mem_fetch(pmem_address[15:4]);
                if (pmem_write) mem[pmem_address[15:4]] = pmem_wdata;
                else pmem_rdata = op.data;
                mem_log.push_back(op);
                pmem_resp = 1'b1;
            end
        end else if (stray_req) begin
            stray_req = 0;
            pmem_resp = 1'b1;
        end else begin
            mem_cnt = 0;
        end
    end

    // ---------------- helpers ----------------
    task automatic do_req(input bit rd, input bit wr, input logic [15:0] addr,
                          input logic [127:0] wd, output logic [127:0] rdat,
                          output int cyc);
        @(negedge clk);
        cache_read    = rd;
        cache_write   = wr;
        cache_address = addr;
        cache_wdata   = wd;
        cyc  = 0;
        rdat = 'x;
        while (cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (cache_resp) begin
                rdat = cache_rdata;
                break;
            end
        end
        cache_read  = 1'b0;
        cache_write = 1'b0;
    endtask

    task automatic wait_log(input int n, output bit ok);
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            if (mem_log.size() >= n) begin
                ok = 1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({cache_resp, pmem_read, pmem_write} !== 3'b000) begin
            errors++;
            $display("FAIL reset_strobes: got %b required 000", {cache_resp, pmem_read, pmem_write});
        end
        checks++;
        if (pmem_address !== 16'h0 || pmem_wdata !== 128'h0 || cache_rdata !== 128'h0) begin
            errors++;
            $display("FAIL reset_data: addr %h wdata %h rdata %h required all zero", pmem_address, pmem_wdata, cache_rdata);
        end
        reset_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_empty_eviction;
        logic [127:0] d, rd;
        int cyc;
        bit ok;
        d = {8{16'hAAAA}};
        mem_log.delete();
        do_req(0, 1, 16'h1230, d, rd, cyc);
        $display("write 1230 -> resp after %0d cycles", cyc);
        checks++;
        if (cyc !== 1) begin
            errors++;
            $display("FAIL empty_evict_latency: got %0d required 1", cyc);
        end
        checks++;
        if (mem_log.size() !== 0) begin
            errors++;
            $display("FAIL empty_evict_no_pmem: got %0d accesses required 0", mem_log.size());
        end
        wait_log(1, ok);
        checks++;
        if (!ok || mem_log[0].wr !== 1'b1 || mem_log[0].addr !== 16'h1230 || mem_log[0].data !== d) begin
            errors++;
            $display("FAIL empty_evict_drain: ok %0d got wr %0d addr %h required wr 1 addr 1230 data AAAA..", ok,
                     ok ? mem_log[0].wr : 1'b0, ok ? mem_log[0].addr : 16'hxxxx);
        end
        $display("drain 1230 observed=%0d", ok);
    endtask

    task automatic test_forward;
        logic [127:0] d, rd;
        int cyc;
        d = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        mem_log.delete();
        do_req(0, 1, 16'h1230, d, rd, cyc);
        checks++;
        if (cyc !== 1) begin
            errors++;
            $display("FAIL fwd_write_latency: got %0d required 1", cyc);
        end
        do_req(1, 0, 16'h1238, '0, rd, cyc);
        $display("read 1238 -> %h after %0d cycles", rd, cyc);
        checks++;
        if (cyc !== 1 || rd !== d) begin
            errors++;
            $display("FAIL fwd_read: got %h at %0d cycles required %h at 1", rd, cyc, d);
        end
        checks++;
        if (mem_log.size() !== 0) begin
            errors++;
            $display("FAIL fwd_no_pmem: got %0d accesses required 0", mem_log.size());
        end
    endtask

    task automatic test_read_bypass;
        logic [127:0] rd;
        int cyc;
        bit ok;
        mem_log.delete();
        do_req(1, 0, 16'h4560, '0, rd, cyc);
        $display("read 4560 -> %h after %0d cycles", rd, cyc);
        checks++;
        if (cyc !== 3 || rd !== {8{16'h4565}}) begin
            errors++;
            $display("FAIL bypass_read: got %h at %0d cycles required 4565.. at 3", rd, cyc);
        end
        checks++;
        if (mem_log.size() !== 1 || mem_log[0].wr !== 1'b0 || mem_log[0].addr !== 16'h4560) begin
            errors++;
            $display("FAIL bypass_order: got %0d accesses, first wr %0d addr %h required read of 4560 only",
                     mem_log.size(), mem_log.size() > 0 ? mem_log[0].wr : 1'b0,
                     mem_log.size() > 0 ? mem_log[0].addr : 16'h0);
        end
        wait_log(2, ok);
        checks++;
        if (!ok || mem_log[1].wr !== 1'b1 || mem_log[1].addr !== 16'h1230 ||
            mem_log[1].data !== 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210) begin
            errors++;
            $display("FAIL bypass_drain: ok %0d, required drain of 1230 after the read", ok);
        end
    endtask

    task automatic test_full_eviction;
        logic [127:0] d3, d4, rd;
        int cyc;
        bit ok;
        d3 = {4{32'h3333_CCCC}};
        d4 = {4{32'h4444_DDDD}};
        mem_log.delete();
        do_req(0, 1, 16'h1230, d3, rd, cyc);
        do_req(0, 1, 16'h7770, d4, rd, cyc);
        $display("write 7770 (buffer full) -> resp after %0d cycles", cyc);
        checks++;
        if (cyc !== 4) begin
            errors++;
            $display("FAIL full_evict_latency: got %0d required 4", cyc);
        end
        checks++;
        if (mem_log.size() !== 1 || mem_log[0].wr !== 1'b1 || mem_log[0].addr !== 16'h1230 || mem_log[0].data !== d3) begin
            errors++;
            $display("FAIL full_evict_drain_first: got %0d accesses addr %h required one write of 1230",
                     mem_log.size(), mem_log.size() > 0 ? mem_log[0].addr : 16'h0);
        end
        do_req(1, 0, 16'h7774, '0, rd, cyc);
        checks++;
        if (cyc !== 1 || rd !== d4) begin
            errors++;
            $display("FAIL full_evict_capture: got %h at %0d cycles required %h at 1", rd, cyc, d4);
        end
        wait_log(2, ok);
        checks++;
        if (!ok || mem_log[1].addr !== 16'h7770 || mem_log[1].data !== d4) begin
            errors++;
            $display("FAIL full_evict_second_drain: ok %0d required drain of 7770", ok);
        end
    endtask

    task automatic test_read_during_drain;
        logic [127:0] d, rd;
        int cyc;
        int w;
        d = {2{64'hD5D5_0000_1111_5D5D}};
        mem_lat = 4;
        mem_log.delete();
        do_req(0, 1, 16'h1230, d, rd, cyc);
        w = 0;
        while (!pmem_write && w < 20) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (!pmem_write) begin
            errors++;
            $display("FAIL drain_start: got pmem_write 0 required 1");
        end
        do_req(1, 0, 16'h1230, '0, rd, cyc);
        $display("read 1230 during drain -> %h after %0d cycles", rd, cyc);
        checks++;
        if (rd !== d) begin
            errors++;
            $display("FAIL drain_read_data: got %h required %h", rd, d);
        end
        checks++;
        if (mem_log.size() !== 2 || mem_log[0].wr !== 1'b1 || mem_log[1].wr !== 1'b0 || mem_log[1].addr !== 16'h1230) begin
            errors++;
            $display("FAIL drain_read_order: got %0d accesses required write then read of 1230", mem_log.size());
        end
        mem_lat = 2;
    endtask

    task automatic test_stray_resp;
        bit seen;
        seen = 0;
        @(negedge clk);
        stray_req = 1;
        repeat (4) begin
            @(negedge clk);
            if (cache_resp || pmem_read || pmem_write) seen = 1;
        end
        $display("stray pmem_resp while idle, activity=%0d", seen);
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL stray_resp: got activity 1 required 0");
        end
    endtask

    task automatic test_async_reset;
        logic [127:0] rd;
        int cyc;
        int w;
        mem_log.delete();
        mem_hold = 1;
        do_req(0, 1, 16'hABC0, {8{16'h6666}}, rd, cyc);
        @(negedge clk);
        cache_read    = 1'b1;
        cache_address = 16'h9990;
        w = 0;
        while (!pmem_read && w < 10) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (!pmem_read || pmem_address !== 16'h9990) begin
            errors++;
            $display("FAIL reset_fill_start: got read %0d addr %h required 1 9990", pmem_read, pmem_address);
        end
        #2 reset_n = 1'b0;
        #1;
        $display("reset asserted mid-FILL");
        checks++;
        if ({cache_resp, pmem_read, pmem_write} !== 3'b000 || pmem_address !== 16'h0 ||
            pmem_wdata !== 128'h0 || cache_rdata !== 128'h0) begin
            errors++;
            $display("FAIL async_reset_outputs: got resp %b rd %b wr %b addr %h required all zero",
                     cache_resp, pmem_read, pmem_write, pmem_address);
        end
        checks++;
        if (dut.u_entry.valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_wb_valid: got %b required 0", dut.u_entry.valid);
        end
        cache_read = 1'b0;
        @(negedge clk);
        reset_n  = 1'b1;
        mem_hold = 0;
        repeat (6) @(negedge clk);
        checks++;
        if (mem_log.size() !== 0) begin
            errors++;
            $display("FAIL async_reset_discard: got %0d accesses required 0", mem_log.size());
        end
        do_req(0, 1, 16'h5550, {8{16'h5555}}, rd, cyc);
        $display("write 5550 after reset -> resp after %0d cycles", cyc);
        checks++;
        if (cyc !== 1) begin
            errors++;
            $display("FAIL async_reset_idle: got %0d required 1", cyc);
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        cache_read    = 1'b0;
        cache_write   = 1'b0;
        cache_address = '0;
        cache_wdata   = '0;
        test_reset();
        test_empty_eviction();
        test_forward();
        test_read_bypass();
        test_full_eviction();
        test_read_during_drain();
        test_stray_resp();
        test_async_reset();
        repeat (4) @(negedge clk);
        checks++;
        if (overlap_seen !== 1'b0) begin
            errors++;
            $display("FAIL strobe_overlap: got 1 required 0");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
